// File: rtl/seg_pkg.sv
// seg_pkg: shared FSM states, A2D channel codes, timeout and sample-period widths
// for the load-cell sampler.
package seg_pkg;
    typedef enum logic [2:0] {IDLE, REQ_L, GAP, REQ_R, UPD} state_e;
    localparam logic [2:0] LFT_CHNL = 3'd0;
    localparam logic [2:0] RGHT_CHNL = 3'd4;
    localparam logic [7:0] A2D_TMO = 8'd255;
    localparam int PER_W_FAST = 10;
    localparam int PER_W_REAL = 20;
endpackage

// File: rtl/box_avg.sv
// box_avg: power-of-two boxcar averager; the first commit after reset primes the
// whole history so the output starts at the raw sample.
module box_avg #(
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic [11:0] din,
    output logic [11:0] dout
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW = 12 + AVG_LOG2;
    logic [11:0] hist_q [DEPTH];
    logic [11:0] hist_d [DEPTH];
    logic [AVG_LOG2-1:0] ptr_q, ptr_d;
    logic [SW-1:0] sum_q, sum_d;
    logic primed_q, primed_d;
    always_comb begin
        hist_d = hist_q;
        ptr_d = ptr_q;
        sum_d = sum_q;
        primed_d = primed_q;
        if (commit && !primed_q) begin
            for (int i = 0; i < DEPTH; i++) hist_d[i] = din;
            sum_d = {din, {AVG_LOG2{1'b0}}};
            ptr_d = '0;
            primed_d = 1'b1;
        end else if (commit) begin
            hist_d[ptr_q] = din;
            sum_d = sum_q + SW'(din) - SW'(hist_q[ptr_q]);
            ptr_d = ptr_q + AVG_LOG2'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '{default: '0};
            ptr_q <= '0;
            sum_q <= '0;
            primed_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            ptr_q <= ptr_d;
            sum_q <= sum_d;
            primed_q <= primed_d;
        end
    end
    assign dout = sum_q[SW-1:AVG_LOG2];
endmodule

// File: rtl/ld_cell_sampler.sv
// ld_cell_sampler: periodic left/right A2D load-cell requests with timeout,
// boxcar filtering and a one-cycle update strobe.
module ld_cell_sampler
    import seg_pkg::*;
#(
    parameter bit fast_sim = 1'b1,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        conv_req,
    output logic [2:0]  chnl,
    input  logic        conv_done,
    input  logic [11:0] res,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic        smpl_vld,
    output logic        a2d_err
);
    localparam int TW = fast_sim ? PER_W_FAST : PER_W_REAL;
    state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0] wait_q, wait_d;
    logic [11:0] lft_hold_q, lft_hold_d, rght_hold_q, rght_hold_d;
    logic smpl_vld_q, smpl_vld_d, a2d_err_q, a2d_err_d;
    logic tick, commit, tmo;
    assign tick = &timer_q;
    assign timer_d = timer_q + TW'(1);
    assign tmo = wait_q == A2D_TMO - 8'd1;
    assign commit = state_q == UPD;
    always_comb begin
        state_d = state_q;
        wait_d = wait_q;
        lft_hold_d = lft_hold_q;
        rght_hold_d = rght_hold_q;
        smpl_vld_d = 1'b0;
        a2d_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = tick ? REQ_L : IDLE;
                wait_d = '0;
            end
            REQ_L: begin
                if (conv_done) begin
                    lft_hold_d = res;
                    state_d = GAP;
                end else if (tmo) begin
                    a2d_err_d = 1'b1;
                    state_d = IDLE;
                end else wait_d = wait_q + 8'd1;
            end
            GAP: begin
                state_d = REQ_R;
                wait_d = '0;
            end
            REQ_R: begin
                if (conv_done) begin
                    rght_hold_d = res;
                    state_d = UPD;
                end else if (tmo) begin
                    a2d_err_d = 1'b1;
                    state_d = IDLE;
                end else wait_d = wait_q + 8'd1;
            end
            UPD: begin
                smpl_vld_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            wait_q <= '0;
            lft_hold_q <= '0;
            rght_hold_q <= '0;
            smpl_vld_q <= 1'b0;
            a2d_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            wait_q <= wait_d;
            lft_hold_q <= lft_hold_d;
            rght_hold_q <= rght_hold_d;
            smpl_vld_q <= smpl_vld_d;
            a2d_err_q <= a2d_err_d;
        end
    end
    assign conv_req = state_q == REQ_L || state_q == REQ_R;
    assign chnl = state_q == REQ_R ? RGHT_CHNL : LFT_CHNL;
    assign smpl_vld = smpl_vld_q;
    assign a2d_err = a2d_err_q;
    box_avg #(.AVG_LOG2(AVG_LOG2)) u_lft (
        .clk(clk), .rst(rst), .commit(commit), .din(lft_hold_q), .dout(lft_ld)
    );
    box_avg #(.AVG_LOG2(AVG_LOG2)) u_rght (
        .clk(clk), .rst(rst), .commit(commit), .din(rght_hold_q), .dout(rght_ld)
    );
endmodule

// File: tb/tb_ld_cell_sampler.sv
// tb_ld_cell_sampler: directed checks of scheduling, filtering, timeout and reset
// using a small A2D responder with programmable latency per channel.
module tb_ld_cell_sampler;
    logic clk = 1'b0, rst = 1'b1;
    logic conv_req, conv_done = 1'b0, smpl_vld, a2d_err;
    logic [2:0] chnl;
    logic [11:0] res = '0, lft_ld, rght_ld;
    logic [11:0] lval = 12'h300, rval = 12'h100;
    logic l_en = 1'b1, r_en = 1'b1, spur = 1'b0;
    int lat = 5, cnt = 0, cyc = 0, t_rdone = 0;
    int total = 0, bad = 0;

    typedef struct {
        logic [11:0] l, r, el, er;
    } vec_t;
    vec_t tab[7];

    ld_cell_sampler #(.fast_sim(1'b1), .AVG_LOG2(2)) dut (
        .clk(clk), .rst(rst), .conv_req(conv_req), .chnl(chnl),
        .conv_done(conv_done), .res(res), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .smpl_vld(smpl_vld), .a2d_err(a2d_err)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A2D responder: answers a held request after lat cycles
    always @(negedge clk) begin
        if (conv_req && (chnl == 3'd4 ? r_en : l_en)) begin
            cnt = cnt + 1;
            conv_done = (cnt == lat);
            res = chnl == 3'd4 ? rval : lval;
            if (conv_done && chnl == 3'd4) t_rdone = cyc;
        end else begin
            cnt = 0;
            conv_done = spur;
            res = spur ? 12'hFFF : 12'h000;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_vld(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (smpl_vld) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_req(output bit ok, output int n);
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n++;
            if (conv_req) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        bit ok, seen;
        int n, t0;
        tab[0] = '{12'h300, 12'h100, 12'h300, 12'h100};
        tab[1] = '{12'h400, 12'h100, 12'h340, 12'h100};
        tab[2] = '{12'h400, 12'h100, 12'h380, 12'h100};
        tab[3] = '{12'h400, 12'h100, 12'h3C0, 12'h100};
        tab[4] = '{12'h400, 12'h100, 12'h400, 12'h100};
        tab[5] = '{12'h400, 12'h200, 12'h400, 12'h140};
        tab[6] = '{12'h400, 12'h200, 12'h400, 12'h180};

        repeat (5) @(negedge clk);
        chk("rst_conv_req", conv_req, 0);
        chk("rst_chnl", chnl, 0);
        chk("rst_lft", lft_ld, 0);
        chk("rst_rght", rght_ld, 0);
        chk("rst_smpl_vld", smpl_vld, 0);
        chk("rst_a2d_err", a2d_err, 0);
        rst = 1'b0;

        wait_req(ok, n);
        chk("req_seen", ok, 1);
        chk("req_rise_cycle", n, 1024);
        chk("chnl_left", chnl, 0);
        n = 0;
        while (conv_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("left_req_len", n, 5);
        chk("gap_chnl", chnl, 0);
        n = 0;
        while (!conv_req && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("gap_len", n, 1);
        chk("chnl_right", chnl, 4);

        for (int i = 0; i < 7; i++) begin
            lval = tab[i].l;
            rval = tab[i].r;
            wait_vld(ok);
            chk($sformatf("vec%0d_vld", i), ok, 1);
            chk($sformatf("vec%0d_lft", i), lft_ld, tab[i].el);
            chk($sformatf("vec%0d_rght", i), rght_ld, tab[i].er);
            @(negedge clk);
            chk($sformatf("vec%0d_vld_pulse", i), smpl_vld, 0);
        end

        spur = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | conv_req | smpl_vld;
        end
        spur = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | conv_req | smpl_vld;
        end
        chk("spur_no_activity", seen, 0);
        chk("spur_lft", lft_ld, 12'h400);
        chk("spur_rght", rght_ld, 12'h180);

        r_en = 1'b0;
        lval = 12'h800;
        wait_req(ok, n);
        chk("tmo_left_req", ok, 1);
        n = 0;
        while (!(conv_req && chnl == 3'd4) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_right_req", conv_req && chnl == 3'd4, 1);
        n = 0;
        seen = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            seen = seen | smpl_vld;
            if (a2d_err) break;
        end
        chk("tmo_cycles", n, 255);
        chk("tmo_conv_req", conv_req, 0);
        chk("tmo_no_vld", seen, 0);
        chk("tmo_lft", lft_ld, 12'h400);
        chk("tmo_rght", rght_ld, 12'h180);
        @(negedge clk);
        chk("tmo_err_pulse", a2d_err, 0);

        r_en = 1'b1;
        lval = 12'h400;
        rval = 12'h200;
        wait_vld(ok);
        chk("retry_vld", ok, 1);
        chk("retry_lft", lft_ld, 12'h400);
        chk("retry_rght", rght_ld, 12'h1C0);

        lat = 200;
        wait_vld(ok);
        t0 = cyc;
        chk("lat200_vld", ok, 1);
        chk("done_to_vld", t0 - t_rdone, 2);
        chk("lat200_rght", rght_ld, 12'h200);
        wait_vld(ok);
        chk("lat200_vld2", ok, 1);
        chk("vld_period", cyc - t0, 1024);
        chk("lat200_lft", lft_ld, 12'h400);

        wait_req(ok, n);
        chk("mid_req", ok, 1);
        repeat (10) @(negedge clk);
        chk("mid_req_held", conv_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", conv_req, 0);
        chk("mid_rst_lft", lft_ld, 0);
        chk("mid_rst_rght", rght_ld, 0);
        @(negedge clk);
        lat = 5;
        lval = 12'h123;
        rval = 12'h456;
        rst = 1'b0;
        wait_vld(ok);
        chk("reprime_vld", ok, 1);
        chk("reprime_lft", lft_ld, 12'h123);
        chk("reprime_rght", rght_ld, 12'h456);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
